pifo_pop_sched: RTL and testbench
=================================

// Module: pifo_pop_sched
// PURPOSE
//  Downstream egress pop scheduler for the PIFO. Each cycle it picks one output
//  port round-robin, gated by per-port credit, a per-port empty flag and output
//  buffer space, and drives pop_0/oprt_0 into the PIFO.
//  It captures the PIFO response one cycle later into a small output FIFO that
//  drains over a valid/ready interface. It snoops the PIFO push inputs to re-arm
//  ports whose last pop missed.
// PARAMETERS
//  NUMPORT    4   number of egress ports scheduled (NUMPORT <= 2**BITPORT)
//  BITPORT    8   port id width (matches PIFO)
//  BITPRIO    16  rank width (matches PIFO)
//  BITDATA    32  descriptor width (matches PIFO)
//  FIFODEPTH  4   output FIFO entries (power of 2, >= 2)
//  CREDIT_INI 2   credits per port after reset; also the saturation maximum
// PORTS
//  clk        in   1                     clock
//  rst        in   1                     synchronous active-high reset
//  pop_0      out  1                     pop request to PIFO (combinational from state)
//  oprt_0     out  BITPORT               port of pop request
//  ovld_0     in   1                     PIFO hit, one cycle after pop_0
//  opri_0     in   BITPRIO               popped rank, valid with ovld_0
//  odout_0    in   BITDATA               popped descriptor, valid with ovld_0
//  push_1     in   1                     snooped PIFO push 1
//  uprt_1     in   BITPORT               snooped push 1 port
//  push_2     in   1                     snooped PIFO push 2
//  uprt_2     in   BITPORT               snooped push 2 port
//  cred_ret   in   NUMPORT               one-hot/multi-hot credit return, +1 per set bit
//  dvld       out  1                     output FIFO head valid
//  drdy       in   1                     downstream accepts head when dvld&&drdy
//  dprt       out  BITPORT               head port
//  dpri       out  BITPRIO               head rank
//  ddat       out  BITDATA               head descriptor
//  cred_err   out  1                     sticky: credit return at saturation
// BEHAVIOUR
//  Reset (rst=1 at edge):
//   - credit[p]=CREDIT_INI, empty[p]=1, rr_ptr=0, FIFO empty, pend=0, cred_err=0.
//   - Outputs: pop_0=0, dvld=0.
//  Eligibility of port p in cycle t:
//   - credit[p]>0 && !empty[p] && (fifo_cnt + pend) < FIFODEPTH.
//   - pend = pop issued in t-1. drdy is never used in eligibility.
//  Issue:
//   - First eligible port at or after rr_ptr (mod NUMPORT) -> pop_0=1, oprt_0=p.
//   - Then rr_ptr<=p+1 mod NUMPORT, credit[p]-=1, pend<=1, pend_prt<=p.
//   - No eligible port -> pop_0=0, oprt_0=0, rr_ptr held.
//   - At most one pop per cycle.
//  Response (cycle t+1, pend=1):
//   - ovld_0=1 -> write {pend_prt,opri_0,odout_0} into FIFO.
//   - ovld_0=0 (miss) -> credit[pend_prt]+=1 (refund). Set empty[pend_prt] unless
//     pend_clr=1 or a push to pend_prt is snooped this cycle.
//   - pend_clr = push to pend_prt snooped in the issue cycle.
//   - ovld_0 when pend=0 is ignored.
//  Snoop:
//   - push_1 (or push_2) with uprt < NUMPORT clears empty[uprt] next cycle.
//   - Clear has priority over a same-cycle miss set.
//  Credit arithmetic, per port per cycle:
//   - next = cur - issue + refund + cred_ret[p]; all three may coincide.
//   - If next > CREDIT_INI, clamp to CREDIT_INI and set cred_err (sticky until rst).
//  FIFO:
//   - Write at response, read on dvld&&drdy; simultaneous read/write allowed, also
//     when full-1/empty.
//   - dvld = fifo_cnt!=0; head fields are stable while dvld && !drdy.
//   - Pointers wrap mod FIFODEPTH; overflow is impossible by eligibility rule.
//  Latency:
//   - Issue to FIFO write is 1 cycle; FIFO write to dvld is 1 cycle.
//   - Throughput is 1 pop/cycle with drdy held high.
//  Reset mid-operation: in-flight response discarded (pend cleared), FIFO flushed.
// TESTING
//  T1:
//   - Stimulus: reset; no pushes for 20 cycles.
//   - Response: pop_0 stays 0, dvld=0.
//  T2:
//   - Stimulus: push port 1 once; pop_0 issued with oprt_0=1; PIFO returns
//     ovld_0=1, pri=5, data=0xA5.
//   - Response: dvld with dprt=1, dpri=5, ddat=0xA5; credit[1]=1.
//  T3:
//   - Stimulus: ports 0..3 re-armed by pushes, all hits, drdy=1.
//   - Response: issue order 0,1,2,3,0,1,2,3; ninth cycle no issue because credit
//     is exhausted until cred_ret.
//  T4:
//   - Stimulus: pop port 2 with ovld_0=0.
//   - Response: credit[2] refunded, empty[2]=1, no port-2 pop until a push to
//     port 2.
//   - Stimulus: repeat with push to port 2 in the issue cycle.
//   - Response: empty[2] stays 0.
//  T5:
//   - Stimulus: drdy=0, continuous hits.
//   - Response: exactly FIFODEPTH=4 entries accepted, pop_0 stays 0, no loss;
//     drdy=1 resumes.
//  T6:
//   - Stimulus: cred_ret[0] with credit[0]=2.
//   - Response: cred_err=1, credit[0]=2.
//   - Stimulus: rst asserted while pend=1.
//   - Response: response dropped, dvld=0 next cycle.

Source files
------------

// File: rtl/pifo_pop_sched.sv
// pifo_pop_sched: egress pop scheduler for the PIFO.
// Each cycle it picks one eligible egress port round-robin and pops it from the
// PIFO. A port is eligible when it has credit, is not known to be empty, and the
// output FIFO has room for everything already stored or in flight.
// The PIFO answers one cycle after the pop. A hit is stored in a small output
// FIFO that drains over dvld/drdy. A miss refunds the credit and marks the port
// empty, unless a snooped push to that port shows it has been refilled.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   pop_0, oprt_0               pop request and its port (from state only)
//   ovld_0, opri_0, odout_0     PIFO response, one cycle after pop_0
//   push_1/uprt_1, push_2/uprt_2  snooped PIFO pushes (re-arm ports)
//   cred_ret                    per-port credit return, +1 per set bit
//   dvld, drdy, dprt, dpri, ddat  output FIFO head, valid/ready
//   cred_err                    sticky flag: credit returned at saturation
module pifo_pop_sched #(
    parameter int NUMPORT    = 4,
    parameter int BITPORT    = 8,
    parameter int BITPRIO    = 16,
    parameter int BITDATA    = 32,
    parameter int FIFODEPTH  = 4,
    parameter int CREDIT_INI = 2
) (
    input  logic               clk,
    input  logic               rst,
    output logic               pop_0,
    output logic [BITPORT-1:0] oprt_0,
    input  logic               ovld_0,
    input  logic [BITPRIO-1:0] opri_0,
    input  logic [BITDATA-1:0] odout_0,
    input  logic               push_1,
    input  logic [BITPORT-1:0] uprt_1,
    input  logic               push_2,
    input  logic [BITPORT-1:0] uprt_2,
    input  logic [NUMPORT-1:0] cred_ret,
    output logic               dvld,
    input  logic               drdy,
    output logic [BITPORT-1:0] dprt,
    output logic [BITPRIO-1:0] dpri,
    output logic [BITDATA-1:0] ddat,
    output logic               cred_err
);
    localparam int CW  = $clog2(CREDIT_INI + 1);
    localparam int FAW = $clog2(FIFODEPTH);
    localparam int EW  = BITPORT + BITPRIO + BITDATA;
    localparam logic signed [CW+1:0] CRED_MAX = (CW+2)'(CREDIT_INI);
    localparam logic signed [CW+1:0] ONE      = (CW+2)'(1);

    logic [CW-1:0]         credit   [NUMPORT];
    logic [CW-1:0]         cred_nxt [NUMPORT];
    logic signed [CW+1:0]  cred_sum [NUMPORT];
    logic [NUMPORT-1:0]    empty;
    logic [NUMPORT-1:0]    snoop_hit;
    logic [NUMPORT-1:0]    elig;
    logic [NUMPORT-1:0]    issue_oh;
    logic [NUMPORT-1:0]    refund;
    logic [NUMPORT-1:0]    cred_ovf;
    logic [BITPORT-1:0]    rr_ptr;
    logic [BITPORT-1:0]    rr_nxt;
    logic                  found;

    logic                  pend_p1;
    logic                  pend_clr_p1;
    logic [BITPORT-1:0]    pend_prt_p1;

    logic [EW-1:0]         fifo_mem [FIFODEPTH];
    logic [FAW-1:0]        wr_ptr;
    logic [FAW-1:0]        rd_ptr;
    logic [FAW:0]          fifo_cnt;
    logic [FAW+1:0]        occ;
    logic                  space_ok;
    logic                  wr_en;
    logic                  rd_en;

    function automatic logic [CW-1:0] sat_credit(input logic signed [CW+1:0] v);
        if (v > CRED_MAX) return CW'(CREDIT_INI);
        return v[CW-1:0];
    endfunction

    always_comb begin
        occ       = {1'b0, fifo_cnt} + {{(FAW+1){1'b0}}, pend_p1};
        space_ok  = occ < (FAW+2)'(FIFODEPTH);
        snoop_hit = '0;
        elig      = '0;
        refund    = '0;
        for (int p = 0; p < NUMPORT; p++) begin
            snoop_hit[p] = (push_1 && uprt_1 == BITPORT'(p)) ||
                           (push_2 && uprt_2 == BITPORT'(p));
            elig[p]      = (credit[p] != '0) && !empty[p] && space_ok;
            refund[p]    = pend_p1 && !ovld_0 && (pend_prt_p1 == BITPORT'(p));
        end
    end

    // Issue stage (p0): round-robin pick, upper ports first, then wrap from 0.
    always_comb begin
        pop_0    = 1'b0;
        oprt_0   = '0;
        issue_oh = '0;
        rr_nxt   = rr_ptr;
        found    = 1'b0;
        for (int i = 0; i < NUMPORT; i++) begin
            if (!found && BITPORT'(i) >= rr_ptr && elig[i]) begin
                found       = 1'b1;
                issue_oh[i] = 1'b1;
                oprt_0      = BITPORT'(i);
                rr_nxt      = (i == NUMPORT - 1) ? '0 : BITPORT'(i + 1);
            end
        end
        for (int i = 0; i < NUMPORT; i++) begin
            if (!found && elig[i]) begin
                found       = 1'b1;
                issue_oh[i] = 1'b1;
                oprt_0      = BITPORT'(i);
                rr_nxt      = (i == NUMPORT - 1) ? '0 : BITPORT'(i + 1);
            end
        end
        pop_0 = found;
    end

    always_comb begin
        cred_ovf = '0;
        for (int p = 0; p < NUMPORT; p++) begin
            cred_sum[p] = $signed({2'b00, credit[p]});
            if (issue_oh[p]) cred_sum[p] = cred_sum[p] - ONE;
            if (refund[p])   cred_sum[p] = cred_sum[p] + ONE;
            if (cred_ret[p]) cred_sum[p] = cred_sum[p] + ONE;
            cred_ovf[p] = cred_sum[p] > CRED_MAX;
            cred_nxt[p] = sat_credit(cred_sum[p]);
        end
    end

    assign wr_en = pend_p1 && ovld_0;
    assign rd_en = dvld && drdy;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int p = 0; p < NUMPORT; p++) credit[p] <= CW'(CREDIT_INI);
            empty    <= '1;
            rr_ptr   <= '0;
            pend_p1  <= 1'b0;
            cred_err <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            for (int p = 0; p < NUMPORT; p++) begin
                credit[p] <= cred_nxt[p];
                if (snoop_hit[p])
                    empty[p] <= 1'b0;
                else if (refund[p] && !pend_clr_p1)
                    empty[p] <= 1'b1;
            end
            rr_ptr  <= rr_nxt;
            pend_p1 <= pop_0;
            if (|cred_ovf) cred_err <= 1'b1;
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            if (wr_en && !rd_en)
                fifo_cnt <= fifo_cnt + 1'b1;
            else if (!wr_en && rd_en)
                fifo_cnt <= fifo_cnt - 1'b1;
        end
    end

    // Response stage (p1): remember what was popped and whether its port was
    // refilled in the issue cycle, so a miss does not wrongly mark it empty.
    always_ff @(posedge clk) begin
        pend_prt_p1 <= oprt_0;
        pend_clr_p1 <= |(issue_oh & snoop_hit);
        if (wr_en) fifo_mem[wr_ptr] <= {pend_prt_p1, opri_0, odout_0};
    end

    // Output stage (p2): FIFO head.
    assign dvld = (fifo_cnt != '0);
    assign {dprt, dpri, ddat} = fifo_mem[rd_ptr];

endmodule

// File: tb/tb_pifo_pop_sched.sv
// tb_pifo_pop_sched: directed bench for pifo_pop_sched with a small PIFO
// responder that counts pushes per port and answers each pop one cycle later.
module tb_pifo_pop_sched;
    localparam int NUMPORT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        pop_0;
    logic [7:0]  oprt_0;
    logic        ovld_0;
    logic [15:0] opri_0;
    logic [31:0] odout_0;
    logic        push_1;
    logic [7:0]  uprt_1;
    logic        push_2;
    logic [7:0]  uprt_2;
    logic [3:0]  cred_ret;
    logic        dvld;
    logic        drdy;
    logic [7:0]  dprt;
    logic [15:0] dpri;
    logic [31:0] ddat;
    logic        cred_err;

    int n_tests = 0;
    int n_fail  = 0;

    int          mcnt [NUMPORT];
    int          rsp_cnt;
    logic        hit_nxt;
    logic [15:0] resp_pri;
    logic [31:0] resp_dat;

    int          npop;
    logic [7:0]  q_prt [$];
    logic [31:0] q_dat [$];
    logic [7:0]  exp_ord [8];

    pifo_pop_sched dut (
        .clk(clk), .rst(rst),
        .pop_0(pop_0), .oprt_0(oprt_0),
        .ovld_0(ovld_0), .opri_0(opri_0), .odout_0(odout_0),
        .push_1(push_1), .uprt_1(uprt_1), .push_2(push_2), .uprt_2(uprt_2),
        .cred_ret(cred_ret),
        .dvld(dvld), .drdy(drdy), .dprt(dprt), .dpri(dpri), .ddat(ddat),
        .cred_err(cred_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        push_1 = 1'b0; uprt_1 = '0; push_2 = 1'b0; uprt_2 = '0;
        cred_ret = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic set_push(input logic p1, input logic [7:0] u1, input logic p2, input logic [7:0] u2);
        push_1 = p1; uprt_1 = u1; push_2 = p2; uprt_2 = u2;
    endtask

    // PIFO responder: a pop hits when the port holds pushed entries; pushes
    // seen in the pop cycle itself are not visible to that pop.
    initial begin
        ovld_0 = 1'b0; opri_0 = '0; odout_0 = '0; rsp_cnt = 0;
        for (int p = 0; p < NUMPORT; p++) mcnt[p] = 0;
        forever begin
            @(negedge clk);
            hit_nxt = 1'b0;
            if (rst) begin
                for (int p = 0; p < NUMPORT; p++) mcnt[p] = 0;
                rsp_cnt = 0;
            end else begin
                if (pop_0 && oprt_0 < 8'(NUMPORT) && mcnt[oprt_0[1:0]] > 0) begin
                    hit_nxt = 1'b1;
                    mcnt[oprt_0[1:0]]--;
                end
                if (push_1 && uprt_1 < 8'(NUMPORT)) mcnt[uprt_1[1:0]]++;
                if (push_2 && uprt_2 < 8'(NUMPORT)) mcnt[uprt_2[1:0]]++;
            end
            @(posedge clk);
            #1;
            ovld_0  = hit_nxt;
            opri_0  = resp_pri;
            odout_0 = resp_dat + 32'(rsp_cnt);
            if (hit_nxt) rsp_cnt++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; drdy = 1'b0;
        push_1 = 1'b0; uprt_1 = '0; push_2 = 1'b0; uprt_2 = '0; cred_ret = '0;
        resp_pri = 16'd5; resp_dat = 32'hA5;
        exp_ord = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd0, 8'd1, 8'd2, 8'd3};

        // T1: idle after reset
        do_reset();
        @(negedge clk);
        check("t1_rst_pop", pop_0, 0);
        check("t1_rst_dvld", dvld, 0);
        check("t1_rst_err", cred_err, 0);
        npop = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            @(negedge clk);
            if (pop_0 || dvld) npop++;
        end
        check("t1_idle_activity", npop, 0);

        // T2: single push to port 1
        do_reset();
        drdy = 1'b0;
        set_push(1, 8'd1, 0, 8'd0);
        @(negedge clk);
        check("t2_c0_nopop", pop_0, 0);
        tick(); set_push(0, 8'd0, 0, 8'd0);
        @(negedge clk);
        check("t2_pop", pop_0, 1);
        check("t2_oprt", oprt_0, 1);
        tick();
        @(negedge clk);
        check("t2_repop", pop_0, 1);
        check("t2_repop_prt", oprt_0, 1);
        tick();
        @(negedge clk);
        check("t2_dvld", dvld, 1);
        check("t2_dprt", dprt, 1);
        check("t2_dpri", dpri, 5);
        check("t2_ddat", ddat, 32'hA5);
        check("t2_nocredit", pop_0, 0);
        tick(); drdy = 1'b1;
        @(negedge clk);
        check("t2_credit1", dut.credit[1], 1);
        check("t2_empty1", dut.empty[1], 1);
        check("t2_nopop_empty", pop_0, 0);
        tick();
        @(negedge clk);
        check("t2_drained", dvld, 0);

        // T3: all ports armed, round-robin until credit runs out
        do_reset();
        drdy = 1'b1;
        q_prt.delete();
        for (int c = 0; c < 14; c++) begin
            case (c)
                0, 2:    set_push(1, 8'd0, 1, 8'd1);
                1, 3:    set_push(1, 8'd2, 1, 8'd3);
                default: set_push(0, 8'd0, 0, 8'd0);
            endcase
            @(negedge clk);
            if (c >= 1 && c <= 8) begin
                check($sformatf("t3_pop%0d", c), pop_0, 1);
                check($sformatf("t3_prt%0d", c), oprt_0, exp_ord[c-1]);
            end
            if (c == 9) check("t3_exhausted", pop_0, 0);
            if (dvld && drdy) q_prt.push_back(dprt);
            tick();
        end
        check("t3_drain_cnt", q_prt.size(), 8);
        for (int k = 0; k < 8 && k < q_prt.size(); k++)
            check($sformatf("t3_drain%0d", k), q_prt[k], exp_ord[k]);
        cred_ret = 4'b0001;
        @(negedge clk);
        tick(); cred_ret = '0;
        @(negedge clk);
        check("t3_credret_pop", pop_0, 1);
        check("t3_credret_prt", oprt_0, 0);
        check("t3_no_err", cred_err, 0);

        // T4: miss on port 2, then miss with push in the issue cycle
        do_reset();
        drdy = 1'b1;
        set_push(1, 8'd2, 0, 8'd0);
        @(negedge clk);
        tick(); set_push(0, 8'd0, 0, 8'd0);
        @(negedge clk);
        check("t4_pop_a", oprt_0, 2);
        tick();
        @(negedge clk);
        check("t4_pop_b", pop_0, 1);
        check("t4_pop_b_prt", oprt_0, 2);
        tick();
        @(negedge clk);
        check("t4_c3_nopop", pop_0, 0);
        tick();
        @(negedge clk);
        check("t4_refund", dut.credit[2], 1);
        check("t4_empty_set", dut.empty[2], 1);
        npop = 0;
        for (int c = 0; c < 5; c++) begin
            if (pop_0) npop++;
            tick();
            @(negedge clk);
        end
        check("t4_no_pop_empty", npop, 0);
        set_push(1, 8'd2, 0, 8'd0);
        tick(); set_push(0, 8'd0, 0, 8'd0); cred_ret = 4'b0100;
        @(negedge clk);
        check("t4_rearm_pop", pop_0, 1);
        check("t4_rearm_prt", oprt_0, 2);
        tick(); cred_ret = '0; set_push(1, 8'd2, 0, 8'd0);
        @(negedge clk);
        check("t4_miss_pop", oprt_0, 2);
        tick(); set_push(0, 8'd0, 0, 8'd0);
        @(negedge clk);
        check("t4_c12_nopop", pop_0, 0);
        tick();
        @(negedge clk);
        check("t4_clr_kept_pop", pop_0, 1);
        check("t4_clr_kept_prt", oprt_0, 2);

        // T5: backpressure fills the FIFO to exactly FIFODEPTH
        resp_dat = 32'hD000;
        do_reset();
        drdy = 1'b0;
        npop = 0;
        for (int c = 0; c < 10; c++) begin
            case (c)
                0, 2:    set_push(1, 8'd0, 1, 8'd1);
                1:       set_push(1, 8'd2, 1, 8'd3);
                default: set_push(0, 8'd0, 0, 8'd0);
            endcase
            @(negedge clk);
            if (pop_0) npop++;
            if (c < 9) tick();
        end
        check("t5_pops", npop, 4);
        check("t5_stall", pop_0, 0);
        check("t5_full", dut.fifo_cnt, 4);
        check("t5_head_prt", dprt, 0);
        check("t5_head_dat", ddat, 32'hD000);
        tick(); drdy = 1'b1;
        q_prt.delete(); q_dat.delete();
        for (int c = 10; c < 16; c++) begin
            @(negedge clk);
            if (c == 10) check("t5_c10_nopop", pop_0, 0);
            if (c == 11) begin
                check("t5_resume_pop", pop_0, 1);
                check("t5_resume_prt", oprt_0, 0);
            end
            if (dvld && drdy) begin
                q_prt.push_back(dprt);
                q_dat.push_back(ddat);
            end
            tick();
        end
        check("t5_drain_ge4", q_prt.size() >= 4, 1);
        for (int k = 0; k < 4 && k < q_prt.size(); k++) begin
            check($sformatf("t5_prt%0d", k), q_prt[k], exp_ord[k]);
            check($sformatf("t5_dat%0d", k), q_dat[k], 32'hD000 + 32'(k));
        end

        // T6: credit return at saturation, then reset with a pop in flight
        resp_dat = 32'hA5;
        do_reset();
        drdy = 1'b0;
        cred_ret = 4'b0001;
        @(negedge clk);
        tick(); cred_ret = '0;
        @(negedge clk);
        check("t6_err", cred_err, 1);
        check("t6_clamp", dut.credit[0], 2);
        tick(); set_push(1, 8'd1, 0, 8'd0);
        @(negedge clk);
        check("t6_sticky", cred_err, 1);
        tick(); set_push(0, 8'd0, 0, 8'd0);
        @(negedge clk);
        check("t6_pop", pop_0, 1);
        check("t6_pop_prt", oprt_0, 1);
        tick(); rst = 1'b1;
        @(negedge clk);
        tick(); rst = 1'b0;
        @(negedge clk);
        check("t6_rst_dvld", dvld, 0);
        check("t6_rst_pop", pop_0, 0);
        check("t6_rst_err", cred_err, 0);
        tick();
        @(negedge clk);
        check("t6_rst_dvld2", dvld, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
